// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcode/funct
// constants, datapath select codes and the instruction-class record.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCODE = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_LUI = 4'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        NPC_PC4    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_t;

    typedef enum logic [1:0] {
        GPR_RD  = 2'b00,
        GPR_RT  = 2'b01,
        GPR_R31 = 2'b10
    } gpr_sel_t;

    typedef enum logic [1:0] {
        WD_ALU = 2'b00,
        WD_MDR = 2'b01,
        WD_PC  = 2'b10
    } wd_sel_t;

    typedef struct packed {
        logic r_alu;
        logic jr;
        logic jalr;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic addi;
        logic ori;
        logic lui;
        logic j;
        logic jal;
    } instr_cls_t;

    function automatic alu_op_t funct_alu_op(input logic [5:0] funct);
        case (funct)
            FN_ADDU: return ALU_ADD;
            FN_SUBU: return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            FN_SLL:  return ALU_SLL;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and Zero in, every datapath
// select/enable plus debug state and illegal flag out.
interface mc_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite;
    logic       IRWrite;
    logic       IorD;
    logic       MemWrite;
    logic       RegWrite;
    logic       EXTOp;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] NPCOp;
    logic [1:0] GPRSel;
    logic [1:0] WDSel;
    logic [2:0] state;
    logic       illegal;

    modport master (
        input  Op, Funct, Zero,
        output PCWrite, IRWrite, IorD, MemWrite, RegWrite, EXTOp,
               ALUSrcA, ALUSrcB, ALUOp, NPCOp, GPRSel, WDSel, state, illegal
    );

    modport slave (
        output Op, Funct, Zero,
        input  PCWrite, IRWrite, IorD, MemWrite, RegWrite, EXTOp,
               ALUSrcA, ALUSrcB, ALUOp, NPCOp, GPRSel, WDSel, state, illegal
    );
endinterface

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction classifier: Op/Funct to a one-hot class record
// plus a legal flag (no class matched means undefined instruction).
module mc_ctrl_dec
    import mc_pkg::*;
(
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    output instr_cls_t cls,
    output logic       legal
);

    logic is_r;

    always_comb begin
        is_r      = (Op == OP_RTYPE);
        cls       = '0;
        cls.r_alu = is_r && (Funct == FN_ADDU || Funct == FN_SUBU || Funct == FN_AND ||
                             Funct == FN_OR   || Funct == FN_SLT  || Funct == FN_SLL);
        cls.jr    = is_r && (Funct == FN_JR);
        cls.jalr  = is_r && (Funct == FN_JALR);
        cls.lw    = (Op == OP_LW);
        cls.sw    = (Op == OP_SW);
        cls.beq   = (Op == OP_BEQ);
        cls.bne   = (Op == OP_BNE);
        cls.addi  = (Op == OP_ADDI);
        cls.ori   = (Op == OP_ORI);
        cls.lui   = (Op == OP_LUI);
        cls.j     = (Op == OP_J);
        cls.jal   = (Op == OP_JAL);
        legal     = |cls;
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU controller: FETCH/DCODE/EXE/MEM/WB sequencer driving all
// datapath selects. Optional MC_CTRL_ILLEGAL_TRAP_EN traps undefined opcodes in HALT.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_if.master     bus
);

    state_t     cur, nxt;
    instr_cls_t cls;
    logic       legal;

    logic     pc_write, ir_write, i_or_d, mem_write, reg_write;
    logic     ext_op, alu_src_a, alu_src_b;
    alu_op_t  alu_op;
    npc_op_t  npc_op;
    gpr_sel_t gpr_sel;
    wd_sel_t  wd_sel;

    mc_ctrl_dec u_dec (
        .Op    (bus.Op),
        .Funct (bus.Funct),
        .cls   (cls),
        .legal (legal)
    );

    always_ff @(posedge clk) begin
        if (rst) cur <= S_FETCH;
        else     cur <= nxt;
    end

    always_comb begin
        nxt       = cur;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        i_or_d    = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        ext_op    = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = ALU_NOP;
        npc_op    = NPC_PC4;
        gpr_sel   = GPR_RD;
        wd_sel    = WD_ALU;

        case (cur)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                nxt      = S_DCODE;
            end
            S_DCODE: begin
                // PC already holds PC+4 here, so link writes take WD_PC directly
                if (cls.j || cls.jal) begin
                    pc_write = 1'b1;
                    npc_op   = NPC_JUMP;
                    if (cls.jal) begin
                        reg_write = 1'b1;
                        gpr_sel   = GPR_R31;
                        wd_sel    = WD_PC;
                    end
                    nxt = S_FETCH;
                end else if (cls.jr || cls.jalr) begin
                    pc_write = 1'b1;
                    npc_op   = NPC_JR;
                    if (cls.jalr) begin
                        reg_write = 1'b1;
                        gpr_sel   = GPR_RD;
                        wd_sel    = WD_PC;
                    end
                    nxt = S_FETCH;
                end else if (legal) begin
                    nxt = S_EXE;
                end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    nxt = S_HALT;
`else
                    nxt = S_FETCH;
`endif
                end
            end
            S_EXE: begin
                if (cls.r_alu) begin
                    alu_op    = funct_alu_op(bus.Funct);
                    alu_src_a = (bus.Funct == FN_SLL);
                    nxt       = S_WB;
                end else if (cls.addi || cls.lw || cls.sw) begin
                    ext_op    = 1'b1;
                    alu_src_b = 1'b1;
                    alu_op    = ALU_ADD;
                    nxt       = (cls.lw || cls.sw) ? S_MEM : S_WB;
                end else if (cls.ori) begin
                    alu_src_b = 1'b1;
                    alu_op    = ALU_OR;
                    nxt       = S_WB;
                end else if (cls.lui) begin
                    alu_src_b = 1'b1;
                    alu_op    = ALU_LUI;
                    nxt       = S_WB;
                end else if (cls.beq || cls.bne) begin
                    alu_op   = ALU_SUB;
                    npc_op   = NPC_BRANCH;
                    pc_write = (cls.beq && bus.Zero) || (cls.bne && !bus.Zero);
                    nxt      = S_FETCH;
                end else begin
                    nxt = S_FETCH;
                end
            end
            S_MEM: begin
                i_or_d = 1'b1;
                if (cls.sw) begin
                    mem_write = 1'b1;
                    nxt       = S_FETCH;
                end else begin
                    nxt = S_WB;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                if (cls.r_alu) begin
                    gpr_sel = GPR_RD;
                    wd_sel  = WD_ALU;
                end else if (cls.lw) begin
                    gpr_sel = GPR_RT;
                    wd_sel  = WD_MDR;
                end else begin
                    gpr_sel = GPR_RT;
                    wd_sel  = WD_ALU;
                end
                nxt = S_FETCH;
            end
            S_HALT: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                nxt = S_HALT;
`else
                nxt = S_FETCH;
`endif
            end
            default: nxt = S_FETCH;
        endcase

        // Reset wins over every state so an aborted instruction leaves no partial write
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            i_or_d    = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            ext_op    = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = 1'b0;
            alu_op    = ALU_NOP;
            npc_op    = NPC_PC4;
            gpr_sel   = GPR_RD;
            wd_sel    = WD_ALU;
        end
    end

    assign bus.PCWrite  = pc_write;
    assign bus.IRWrite  = ir_write;
    assign bus.IorD     = i_or_d;
    assign bus.MemWrite = mem_write;
    assign bus.RegWrite = reg_write;
    assign bus.EXTOp    = ext_op;
    assign bus.ALUSrcA  = alu_src_a;
    assign bus.ALUSrcB  = alu_src_b;
    assign bus.ALUOp    = alu_op;
    assign bus.NPCOp    = npc_op;
    assign bus.GPRSel   = gpr_sel;
    assign bus.WDSel    = wd_sel;
    assign bus.state    = cur;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal = (cur == S_HALT) && !rst;
`else
    assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction cycle tables pushed on issue,
// a negedge monitor pops and compares every controller output.
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, irw, iord, memw, regw, ext, srca, srcb;
        logic [3:0] aluop;
        logic [1:0] npc, gpr, wd;
        logic       ill;
    } exp_t;

    localparam int K_RALU = 0, K_JR = 1, K_JALR = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                   K_BNE = 6, K_ADDI = 7, K_ORI = 8, K_LUI = 9, K_J = 10, K_JAL = 11,
                   K_ILL = 12;

    exp_t  sb_q[$];
    string nm_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.st    = bus.state;
        a.pcw   = bus.PCWrite;
        a.irw   = bus.IRWrite;
        a.iord  = bus.IorD;
        a.memw  = bus.MemWrite;
        a.regw  = bus.RegWrite;
        a.ext   = bus.EXTOp;
        a.srca  = bus.ALUSrcA;
        a.srcb  = bus.ALUSrcB;
        a.aluop = bus.ALUOp;
        a.npc   = bus.NPCOp;
        a.gpr   = bus.GPRSel;
        a.wd    = bus.WDSel;
        a.ill   = bus.illegal;
        return a;
    endfunction

    task automatic push(input exp_t e, input string n);
        sb_q.push_back(e);
        nm_q.push_back(n);
    endtask

    // Reference: the instruction's architectural cycle list, derived from its class.
    task automatic expect_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                output int len, output int rk);
        int    kind;
        int    alu;
        string nm;
        exp_t  e;
        alu  = 0;
        rk   = -1;
        kind = K_ILL;
        case (op)
            6'b000000: begin
                kind = K_RALU;
                case (fn)
                    6'b100001: alu = 1;
                    6'b100011: alu = 2;
                    6'b100100: alu = 3;
                    6'b100101: alu = 4;
                    6'b101010: alu = 5;
                    6'b000000: alu = 6;
                    6'b001000: kind = K_JR;
                    6'b001001: kind = K_JALR;
                    default:   kind = K_ILL;
                endcase
            end
            6'b100011: kind = K_LW;
            6'b101011: kind = K_SW;
            6'b000100: kind = K_BEQ;
            6'b000101: kind = K_BNE;
            6'b001000: kind = K_ADDI;
            6'b001101: kind = K_ORI;
            6'b001111: kind = K_LUI;
            6'b000010: kind = K_J;
            6'b000011: kind = K_JAL;
            default:   kind = K_ILL;
        endcase
        nm = $sformatf("op%02h_fn%02h_z%0d", op, fn, z);

        e = mk(3'd0); e.pcw = 1'b1; e.irw = 1'b1;
        push(e, {nm, "_fetch"});
        e = mk(3'd1);
        case (kind)
            K_J:    begin e.pcw = 1; e.npc = 2; end
            K_JAL:  begin e.pcw = 1; e.npc = 2; e.regw = 1; e.gpr = 2; e.wd = 2; end
            K_JR:   begin e.pcw = 1; e.npc = 3; end
            K_JALR: begin e.pcw = 1; e.npc = 3; e.regw = 1; e.gpr = 0; e.wd = 2; end
            default: ;
        endcase
        push(e, {nm, "_dcode"});
        len = 2;
        if (kind == K_J || kind == K_JAL || kind == K_JR || kind == K_JALR) return;

        if (kind == K_ILL) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            for (int i = 0; i < 10; i++) begin
                e = mk(3'd5); e.ill = 1'b1;
                push(e, {nm, "_halt"});
            end
            push(mk(3'd5), {nm, "_halt_rst"});
            len = 13;
            rk  = 12;
`endif
            return;
        end

        e = mk(3'd2);
        case (kind)
            K_BEQ, K_BNE: begin
                e.aluop = 2; e.npc = 1;
                e.pcw   = (kind == K_BEQ) ? z : !z;
            end
            K_RALU: begin e.aluop = alu[3:0]; e.srca = (fn == 6'b000000); end
            K_ADDI, K_LW, K_SW: begin e.ext = 1; e.srcb = 1; e.aluop = 1; end
            K_ORI:  begin e.srcb = 1; e.aluop = 4; end
            K_LUI:  begin e.srcb = 1; e.aluop = 7; end
            default: ;
        endcase
        push(e, {nm, "_exe"});
        len = 3;
        if (kind == K_BEQ || kind == K_BNE) return;

        if (kind == K_LW || kind == K_SW) begin
            e = mk(3'd3); e.iord = 1; e.memw = (kind == K_SW);
            push(e, {nm, "_mem"});
            len = 4;
            if (kind == K_SW) return;
        end

        e = mk(3'd4); e.regw = 1;
        e.gpr = (kind == K_RALU) ? 2'd0 : 2'd1;
        e.wd  = (kind == K_LW) ? 2'd1 : 2'd0;
        push(e, {nm, "_wb"});
        len = len + 1;
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int len, rk;
        expect_instr(op, fn, z, len, rk);
        bus.Op = op; bus.Funct = fn; bus.Zero = z;
        for (int k = 0; k < len; k++) begin
            rst = (k == rk);
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    // lw interrupted by reset during EXE: nothing written, back to FETCH
    task automatic run_abort_lw();
        exp_t e;
        bus.Op = 6'b100011; bus.Funct = 6'h15; bus.Zero = 1'b0;
        e = mk(3'd0); e.pcw = 1; e.irw = 1;
        push(e, "abort_fetch");
        push(mk(3'd1), "abort_dcode");
        push(mk(3'd2), "abort_exe_rst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t  e, a;
        string n;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n = nm_q.pop_front();
            a = actual();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s: got %h want %h (state got %0d want %0d)", n, a, e, a.st, e.st);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [5:0] ops [15];
    logic [5:0] fns [15];

    initial begin
        int         idx;
        logic [5:0] op, fn;
        ops = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                6'b001000, 6'b001101, 6'b001111};
        fns = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b000000,
                6'b001000, 6'b001001, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};

        bus.Op = '0; bus.Funct = '0; bus.Zero = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        push(mk(3'd0), "reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run(6'b100011, 6'h00, 1'b0);
        run(6'b000100, 6'h2a, 1'b1);
        run(6'b000100, 6'h2a, 1'b0);
        run(6'b000101, 6'h2a, 1'b1);
        run(6'b000101, 6'h2a, 1'b0);
        run(6'b000011, 6'h3f, 1'b0);
        run(6'b000000, 6'b000000, 1'b0);
        run(6'b000000, 6'b100011, 1'b1);
        run(6'b111111, 6'h00, 1'b0);
        run_abort_lw();
        run(6'b101011, 6'h07, 1'b1);
        run(6'b000010, 6'h00, 1'b0);

        for (int i = 0; i < 300; i++) begin
            idx = $urandom_range(0, 19);
            if (idx < 15) begin
                op = ops[idx];
                fn = (op == 6'b000000) ? fns[idx] : 6'($urandom);
            end else if (idx < 17) begin
                op = (idx == 15) ? 6'b000010 : 6'b000011;
                fn = 6'($urandom);
            end else begin
                case (idx)
                    17:      begin op = 6'b111111; fn = 6'($urandom); end
                    18:      begin op = 6'b110000; fn = 6'($urandom); end
                    default: begin op = 6'b000000; fn = 6'b000111; end
                endcase
            end
            run(op, fn, 1'($urandom));
        end

        @(posedge clk); #1;
        @(negedge clk); #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
